// File: rtl/int8_mlp_pkg.sv
// Shared types for the int8_mlp_v1_pipelined datapath: INT8 element type and loader FSM states.
package int8_mlp_pkg;

    typedef logic signed [7:0] int8_t;

    typedef enum logic [1:0] {
        LD_IDLE,
        LD_START,
        LD_ARM,
        LD_BUSY
    } ld_state_t;

endpackage

// File: rtl/int8_fc_input_loader_if.sv
// Byte-stream input and FC-layer start/done/vector bus of the input loader.
interface int8_fc_input_loader_if #(
    parameter int IN = 8
);
    import int8_mlp_pkg::*;

    logic           s_valid;
    logic           s_ready;
    int8_t          s_data;
    logic           s_last;
    logic           fc_start;
    logic           fc_done;
    int8_t [IN-1:0] x;
    logic           err_len;

    modport master (
        output s_valid, s_data, s_last, fc_done,
        input  s_ready, fc_start, x, err_len
    );

    modport slave (
        input  s_valid, s_data, s_last, fc_done,
        output s_ready, fc_start, x, err_len
    );

endinterface

// File: rtl/int8_vec_bank.sv
// One IN-entry INT8 vector register bank with a write port and a full flag.
module int8_vec_bank
    import int8_mlp_pkg::*;
#(
    parameter int IN = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   we,
    input  logic [$clog2(IN)-1:0]  waddr,
    input  int8_t                  wdata,
    input  logic                   set_full,
    input  logic                   clr_full,
    output logic                   full,
    output int8_t [IN-1:0]         data
);

    // NOTE: the bank contents are reset along with the flag so x can never show stale data after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data <= '0;
            full <= 1'b0;
        end else begin
            if (we) begin
                data[waddr] <= wdata;
            end
            if (set_full) begin
                full <= 1'b1;
            end else if (clr_full) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/int8_fc_input_loader.sv
// Assembles INT8 byte stream into IN-element vectors and sequences them into int8_fc_pipelined.
// Define INT8_FC_LOADER_DBUF_EN for two ping-pong banks; the default build uses a single bank.
module int8_fc_input_loader
    import int8_mlp_pkg::*;
#(
    parameter int IN = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    int8_fc_input_loader_if.slave bus
);

    localparam int AW = $clog2(IN);
`ifdef INT8_FC_LOADER_DBUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    ld_state_t      state, state_nxt;
    logic [AW-1:0]  wr_idx;
    logic [NB-1:0]  wsel, rsel, full, bank_we, bank_set, bank_clr;
    int8_t [IN-1:0] bank_data [NB];
    int8_t [IN-1:0] rd_data, x_q;
    logic           accept, last_slot, rd_full, done_evt, load_x, err_q;

    assign last_slot   = (wr_idx == AW'(IN - 1));
    assign bus.s_ready = ~|(full & wsel);
    assign accept      = bus.s_valid & bus.s_ready;
    assign rd_full     = |(full & rsel);
    assign bank_we     = {NB{accept}} & wsel;
    assign bank_set    = {NB{accept & last_slot}} & wsel;
    assign bank_clr    = {NB{done_evt}} & rsel;

`ifdef INT8_FC_LOADER_DBUF_EN
    logic wr_ptr, rd_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (accept && last_slot) begin
                wr_ptr <= ~wr_ptr;
            end
            if (done_evt) begin
                rd_ptr <= ~rd_ptr;
            end
        end
    end

    assign wsel = {wr_ptr, ~wr_ptr};
    assign rsel = {rd_ptr, ~rd_ptr};
`else
    assign wsel = 1'b1;
    assign rsel = 1'b1;
`endif

    for (genvar b = 0; b < NB; b++) begin : g_bank
        int8_vec_bank #(.IN(IN)) u_bank (
            .clk      (clk),
            .rst_n    (rst_n),
            .we       (bank_we[b]),
            .waddr    (wr_idx),
            .wdata    (bus.s_data),
            .set_full (bank_set[b]),
            .clr_full (bank_clr[b]),
            .full     (full[b]),
            .data     (bank_data[b])
        );
    end

    always_comb begin
        rd_data = '0;
        for (int b = 0; b < NB; b++) begin
            if (rsel[b]) begin
                rd_data = bank_data[b];
            end
        end
    end

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        done_evt  = 1'b0;
        load_x    = 1'b0;
        case (state)
            LD_IDLE: begin
                if (rd_full) begin
                    state_nxt = LD_START;
                    load_x    = 1'b1;
                end
            end
            LD_START: state_nxt = LD_ARM;
            // fc_done is deliberately not looked at here: a level done left over from
            // the previous vector must not complete this one.
            LD_ARM:   state_nxt = LD_BUSY;
            LD_BUSY: begin
                if (bus.fc_done) begin
                    state_nxt = LD_IDLE;
                    done_evt  = 1'b1;
                end
            end
            default:  state_nxt = LD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= LD_IDLE;
            wr_idx <= '0;
            err_q  <= 1'b0;
            x_q    <= '0;
        end else begin
            state <= state_nxt;
            err_q <= 1'b0;
            if (load_x) begin
                x_q <= rd_data;
            end
            if (accept) begin
                if (last_slot) begin
                    wr_idx <= '0;
                    err_q  <= ~bus.s_last;
                end else if (bus.s_last) begin
                    wr_idx <= '0;
                    err_q  <= 1'b1;
                end else begin
                    wr_idx <= wr_idx + 1'b1;
                end
            end
        end
    end

    assign bus.fc_start = (state == LD_START);
    assign bus.x        = x_q;
    assign bus.err_len  = err_q;

endmodule

// File: tb/tb_int8_fc_input_loader.sv
// Self-checking bench for int8_fc_input_loader: directed steps plus random vectors against a queue model.
module tb_int8_fc_input_loader;
    import int8_mlp_pkg::*;

    localparam int IN = 8;
`ifdef INT8_FC_LOADER_DBUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int8_fc_input_loader_if #(.IN(IN)) bus ();

    int8_fc_input_loader #(.IN(IN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [8*IN-1:0] obs, input logic [8*IN-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8*IN-1:0] pack(input int8_t q[$]);
        logic [8*IN-1:0] r;
        r = '0;
        for (int i = 0; i < q.size() && i < IN; i++) r[8*i +: 8] = q[i];
        return r;
    endfunction

    // FC layer model: pulse or level done fc_dly cycles after start, or done held high.
    int cyc = 0;
    int fc_mode = 0;
    int fc_dly = 5;
    int fst = 0;
    bit fstarted = 0;

    always @(posedge clk) begin
        logic rst_at_edge;
        rst_at_edge = rst_n;
        cyc++;
        #1;
        if (!rst_at_edge) fstarted = 0;
        else if (bus.fc_start === 1'b1) begin
            fst = cyc;
            fstarted = 1;
        end
        case (fc_mode)
            0:       bus.fc_done = fstarted && (cyc == fst + fc_dly);
            1:       bus.fc_done = fstarted && (cyc >= fst + fc_dly);
            default: bus.fc_done = 1'b1;
        endcase
    end

    // Reference model: bytes collect into vectors, full vectors queue for issue, at most NB held.
    bit              armed = 0;
    bit              busy = 0;
    int              sedge = 0;
    int              nfull = 0;
    int8_t           cur[$];
    logic [8*IN-1:0] vq[$];
    logic            exp_ready = 1'b1, exp_start = 1'b0, exp_err = 1'b0;
    logic [8*IN-1:0] exp_x = '0;
    int              obs_err = 0;
    int              obs_start = 0;

    always @(negedge clk) begin
        if (armed) begin
            check("s_ready", bus.s_ready, exp_ready);
            check("fc_start", bus.fc_start, exp_start);
            check("err_len", bus.err_len, exp_err);
            check("x", bus.x, exp_x);
            if (bus.err_len === 1'b1) obs_err++;
            if (bus.fc_start === 1'b1) obs_start++;
        end
        // Predict what the coming edge (cyc+1) produces.
        if (!rst_n) begin
            armed = 1;
            busy = 0;
            nfull = 0;
            cur.delete();
            vq.delete();
            exp_ready = 1'b1;
            exp_start = 1'b0;
            exp_err = 1'b0;
            exp_x = '0;
        end else if (armed) begin
            exp_start = 1'b0;
            exp_err = 1'b0;
            if (!busy && nfull > 0) begin
                busy = 1;
                sedge = cyc + 1;
                exp_start = 1'b1;
                exp_x = vq[0];
            end else if (busy && (cyc + 1 >= sedge + 3) && bus.fc_done === 1'b1) begin
                busy = 0;
                nfull--;
                void'(vq.pop_front());
            end
            if (bus.s_valid === 1'b1 && exp_ready) begin
                cur.push_back(bus.s_data);
                if (cur.size() == IN) begin
                    vq.push_back(pack(cur));
                    nfull++;
                    exp_err = ~bus.s_last;
                    cur.delete();
                end else if (bus.s_last === 1'b1) begin
                    exp_err = 1'b1;
                    cur.delete();
                end
            end
            exp_ready = (nfull < NB);
        end
    end

    task automatic send(input int8_t d, input logic l, output int k);
        bit got;
        got = 0;
        k = -1;
        bus.s_valid = 1'b1;
        bus.s_data = d;
        bus.s_last = l;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge clk);
            got = (bus.s_ready === 1'b1);
            @(posedge clk);
            #1;
        end
        if (got) k = cyc;
        check("send_accepted", got, 1'b1);
        bus.s_valid = 1'b0;
        bus.s_last = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_vec(input int8_t v[$], input bit with_last, input int max_gap, output int k);
        for (int i = 0; i < v.size(); i++) begin
            send(v[i], with_last && (i == v.size() - 1), k);
            if (max_gap > 0 && i < v.size() - 1) gap($urandom_range(0, max_gap));
        end
    endtask

    task automatic rand_vec(output int8_t v[$]);
        v.delete();
        for (int i = 0; i < IN; i++) v.push_back(int8_t'($urandom_range(0, 255)));
    endtask

    task automatic wait_start(output int st);
        bit seen;
        seen = 0;
        st = -1;
        for (int t = 0; t < 300 && !seen; t++) begin
            @(negedge clk);
            if (bus.fc_start === 1'b1) begin
                seen = 1;
                st = cyc;
            end
        end
        check("start_seen", seen, 1'b1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(posedge clk);
            #1;
            ok = !busy && nfull == 0;
        end
        check("idle_reached", ok, 1'b1);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_s_ready", bus.s_ready, 1'b1);
        check("rst_fc_start", bus.fc_start, 1'b0);
        check("rst_err_len", bus.err_len, 1'b0);
        check("rst_x", bus.x, '0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int8_t v[$];
        int8_t ref_stream[$];
        int k, st, s0, e0, plan_err, p;
        bit no_last;

        plan_err = 0;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.s_last = 1'b0;
        bus.fc_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_s_ready", bus.s_ready, 1'b1);
        check("reset_fc_start", bus.fc_start, 1'b0);
        check("reset_err_len", bus.err_len, 1'b0);
        check("reset_x", bus.x, '0);
        @(posedge clk);
        #1;

        // Directed stream, done pulse 5 cycles after start.
        ref_stream = '{8'sd10, -8'sd3, 8'sd7, 8'sd2, -8'sd8, 8'sd1, 8'sd4, -8'sd2};
        fc_mode = 0;
        fc_dly = 5;
        e0 = obs_err;
        send_vec(ref_stream, 1, 0, k);
        wait_start(st);
        check("start_latency", st - k, 1);
        #1;
        check("x_stream", bus.x, pack(ref_stream));
        wait_idle();
        check("no_err_clean", obs_err - e0, 0);

        // Early s_last on the 3rd byte, then a clean vector.
        s0 = obs_start;
        e0 = obs_err;
        for (int i = 0; i < 3; i++) send(int8_t'(i + 40), i == 2, k);
        plan_err++;
        rand_vec(v);
        send_vec(v, 1, 0, k);
        wait_idle();
        check("early_last_err", obs_err - e0, 1);
        check("early_last_issue", obs_start - s0, 1);

        // Eight bytes without s_last.
        s0 = obs_start;
        e0 = obs_err;
        rand_vec(v);
        send_vec(v, 0, 0, k);
        plan_err++;
        wait_idle();
        check("no_last_err", obs_err - e0, 1);
        check("no_last_issue", obs_start - s0, 1);

        // Back-to-back vectors against a level done.
        fc_mode = 1;
        fc_dly = 5;
        s0 = obs_start;
        rand_vec(v);
        send_vec(v, 1, 0, k);
        rand_vec(v);
        send_vec(v, 1, 0, k);
        wait_idle();
        check("b2b_issue", obs_start - s0, 2);

        // done held high before and across start.
        fc_mode = 2;
        gap(3);
        s0 = obs_start;
        rand_vec(v);
        send_vec(v, 1, 0, k);
        wait_idle();
        gap(4);
        check("forced_done_issue", obs_start - s0, 1);
        fc_mode = 0;
        gap(2);

        // Reset mid-BUSY, then mid-fill, then a normal vector.
        fc_dly = 20;
        e0 = obs_err;
        rand_vec(v);
        send_vec(v, 1, 0, k);
        wait_start(st);
        gap(4);
        pulse_reset();
        for (int i = 0; i < 3; i++) send(int8_t'($urandom_range(0, 255)), 1'b0, k);
        pulse_reset();
        fc_dly = 5;
        s0 = obs_start;
        rand_vec(v);
        send_vec(v, 1, 0, k);
        wait_start(st);
        check("post_reset_latency", st - k, 1);
        wait_idle();
        check("post_reset_issue", obs_start - s0, 1);
        check("reset_no_err", obs_err - e0, 0);

        // Random vectors with gaps and occasional framing errors.
        fc_mode = $urandom_range(0, 1);
        for (int n = 0; n < 8; n++) begin
            fc_dly = $urandom_range(3, 8);
            if ($urandom_range(0, 3) == 0) begin
                p = $urandom_range(1, IN - 1);
                for (int i = 0; i < p; i++) send(int8_t'($urandom_range(0, 255)), i == p - 1, k);
                plan_err++;
            end
            no_last = ($urandom_range(0, 4) == 0);
            if (no_last) plan_err++;
            rand_vec(v);
            send_vec(v, !no_last, 2, k);
        end
        wait_idle();
        check("queue_drained", vq.size(), 0);
        check("err_total", obs_err, plan_err);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
